// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path: RISC-V memory opcodes,
// the responder FSM state encoding and the word-index width helper.
package riscv_mem_pkg;

  localparam logic [6:0]  LW  = 7'b000_0011;
  localparam logic [6:0]  SW  = 7'b010_0011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Width of a word index into an array of 'depth' words (at least 1 bit).
  function automatic int word_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word array with per-byte write enables and a
// registered read port (read-first on a same-cycle write).
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = word_idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage has no reset; its contents are undefined until written,
  // and adding a reset would turn the array into flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits it to the
// word array after LATENCY cycles and holds the response until it is taken.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int              AW       = word_idx_w(DEPTH);
  localparam int              CW       = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

  dmem_state_e state, state_nxt;

  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  logic          accept;
  logic          commit;
  logic          addr_err;
  logic          arr_en;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [31:0]   rd_word;

  assign accept   = (state == IDLE) && req_valid;
  assign commit   = (state == BUSY) && (cnt == '0);
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    ({2'b00, lat_addr[31:2]} >= 32'(DEPTH));

  // The array reads every cycle; the read registered on the edge before the
  // commit edge supplies load data. With LATENCY=1 that is the accept edge
  // itself, so the address comes straight from the request while idle.
  assign arr_en   = (state != RESP);
  assign arr_we   = commit && lat_we && !addr_err;
  assign arr_addr = (state == IDLE) ? req_addr[AW+1:2] : lat_addr[AW+1:2];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .be    (lat_be),
    .wdata (lat_wdata),
    .rdata (rd_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Response fields change only on the commit edge, so they stay stable for
  // the whole RESP state and keep the last value afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= addr_err;
      rsp_rdata <= (addr_err || lat_we) ? 32'h0 : rd_word;
    end
  end

endmodule
